// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 VGA timing constants, derived totals and
//               sync window bounds, plus the shared line-wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  // Default timing for 640x480@60 with a 25 MHz pixel clock
  localparam int C_H_VISIBLE = 640;
  localparam int C_H_FRONT   = 16;
  localparam int C_H_SYNC    = 96;
  localparam int C_H_BACK    = 48;
  localparam int C_V_VISIBLE = 480;
  localparam int C_V_FRONT   = 10;
  localparam int C_V_SYNC    = 2;
  localparam int C_V_BACK    = 33;

  // Derived totals and sync windows; each window is [start, end)
  localparam int C_H_TOTAL      = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;
  localparam int C_V_TOTAL      = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;
  localparam int C_H_SYNC_START = C_H_VISIBLE + C_H_FRONT;
  localparam int C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC;
  localparam int C_V_SYNC_START = C_V_VISIBLE + C_V_FRONT;
  localparam int C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC;

  // Pixel coordinate width; both visible dimensions fit below 1024
  localparam int C_PIX_W = 10;

  // Next line number with wrap; anything at or past the last line wraps to 0
  function automatic logic [15:0] next_line(input logic [15:0] cur,
                                            input logic [15:0] total);
    return (cur >= total - 16'd1) ? 16'd0 : cur + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_line_counter.sv
// ============================================================================
// Module      : vga_line_counter
// Description : Vertical line counter advanced by the end-of-line strobe.
//               Also exports the effective line (next value when the strobe
//               is high) so decodes line up with H_counter==0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_line_counter
  import vga_timing_pkg::*;
#(
  parameter int V_TOTAL = C_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena_V,
  output logic [15:0] V_counter,
  output logic [15:0] v_line
);

  localparam logic [15:0] c_v_total = 16'(V_TOTAL);

  logic [15:0] v_cnt_q;
  logic [15:0] v_cnt_d;

  // Next line value: advance with wrap on the strobe, otherwise hold
  always_comb begin
    v_cnt_d = v_cnt_q;
    if (ena_V) begin
      v_cnt_d = next_line(v_cnt_q, c_v_total);
    end
  end

  // Line counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_cnt_q <= 16'd0;
    end else begin
      v_cnt_q <= v_cnt_d;
    end
  end

  assign V_counter = v_cnt_q;
  // The effective line is exactly the next-state value
  assign v_line    = v_cnt_d;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : Vertical counter plus registered sync/blank decode producing
//               hsync, vsync, video_on, pixel coordinates and frame_start.
//               Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = C_H_VISIBLE,
  parameter int H_FRONT   = C_H_FRONT,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BACK    = C_H_BACK,
  parameter int V_VISIBLE = C_V_VISIBLE,
  parameter int V_FRONT   = C_V_FRONT,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BACK    = C_V_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena_V,
  input  logic [15:0]        H_counter,
  output logic [15:0]        V_counter,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [C_PIX_W-1:0] pixel_x,
  output logic [C_PIX_W-1:0] pixel_y,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]        frame_cnt,
`endif
  output logic               frame_start
);

  // 16-bit decode bounds; H_BACK only matters upstream for the line length
  localparam int          c_v_total       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [15:0] c_h_visible     = 16'(H_VISIBLE);
  localparam logic [15:0] c_v_visible     = 16'(V_VISIBLE);
  localparam logic [15:0] c_h_sync_start  = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] c_h_sync_end    = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] c_v_sync_start  = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] c_v_sync_end    = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [15:0]        w_v_line;
  logic               w_video_on;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_frame_start;

  logic               hsync_q;
  logic               vsync_q;
  logic               video_on_q;
  logic [C_PIX_W-1:0] pixel_x_q;
  logic [C_PIX_W-1:0] pixel_y_q;
  logic               frame_start_q;

  vga_line_counter #(
    .V_TOTAL   (c_v_total)
  ) u_line_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_V     (ena_V),
    .V_counter (V_counter),
    .v_line    (w_v_line)
  );

  // Combinational decode of the current pixel position; out-of-range
  // H_counter falls outside every window and so reads as blanking
  always_comb begin
    w_video_on    = (H_counter < c_h_visible) && (w_v_line < c_v_visible);
    w_hsync       = !((H_counter >= c_h_sync_start) && (H_counter < c_h_sync_end));
    w_vsync       = !((w_v_line >= c_v_sync_start) && (w_v_line < c_v_sync_end));
    w_frame_start = (H_counter == 16'd0) && (w_v_line == 16'd0);
  end

  // Output registers: one clock of latency from H_counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= w_hsync;
      vsync_q       <= w_vsync;
      video_on_q    <= w_video_on;
      pixel_x_q     <= w_video_on ? H_counter[C_PIX_W-1:0] : '0;
      pixel_y_q     <= w_video_on ? w_v_line[C_PIX_W-1:0]  : '0;
      frame_start_q <= w_frame_start;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter: counts each registered frame_start pulse, wraps mod 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_start_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen: directed vector table
//               plus line sweeps, frame wrap, mid-frame reset and (with
//               VGA_FRAME_CNT_EN) the frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  logic        clk;
  logic        rst_n;
  logic        ena_V;
  logic [15:0] H_counter;
  logic [15:0] V_counter;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_sync_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena_V       (ena_V),
    .H_counter   (H_counter),
    .V_counter   (V_counter),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] h;
    logic        e;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        von;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        fs;
  } vec_t;

  vec_t vec [12];

  int n_pass;
  int n_total;
  int fs_cnt;
  int cur_v;
  int hs_low;
  int vs_low;
  int von_hi;
  int first_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one pixel, then sample #1 after the edge that registered it
  task automatic step(input logic [15:0] h, input logic e);
    @(negedge clk);
    H_counter = h;
    ena_V     = e;
    @(posedge clk);
    #1;
    if (e) cur_v = (cur_v >= 524) ? 0 : cur_v + 1;
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  // Fast line advance: strobe at H=0 then one out-of-range blank pixel
  task automatic adv_to(input int target);
    while (cur_v != target) begin
      step(16'd0, 1'b1);
      step(16'd800, 1'b0);
    end
    chk("adv_V", 32'(V_counter), 32'(target));
  endtask

  // Full line: strobe with H=0, then 1..799; counts output activity
  task automatic sweep();
    hs_low = 0; von_hi = 0; first_hs = -1;
    for (int h = 0; h < 800; h++) begin
      step(16'(h), (h == 0));
      if (hsync === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = h;
      end
      if (vsync === 1'b0) vs_low++;
      if (video_on === 1'b1) von_hi++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_V"},   32'(V_counter),  32'd0);
    chk({tag, "_hs"},  32'(hsync),      32'd1);
    chk({tag, "_vs"},  32'(vsync),      32'd1);
    chk({tag, "_von"}, 32'(video_on),   32'd0);
    chk({tag, "_px"},  32'(pixel_x),    32'd0);
    chk({tag, "_py"},  32'(pixel_y),    32'd0);
    chk({tag, "_fs"},  32'(frame_start), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; fs_cnt = 0; cur_v = 0; vs_low = 0;
    rst_n = 1'b0; ena_V = 1'b0; H_counter = 16'd0;

    //           h       e     V      hs    vs    von   px      py     fs
    vec[0]  = '{16'd0,   1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1, 1'b0};
    vec[1]  = '{16'd1,   1'b0, 16'd1, 1'b1, 1'b1, 1'b1, 10'd1,   10'd1, 1'b0};
    vec[2]  = '{16'd639, 1'b0, 16'd1, 1'b1, 1'b1, 1'b1, 10'd639, 10'd1, 1'b0};
    vec[3]  = '{16'd640, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[4]  = '{16'd655, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[5]  = '{16'd656, 1'b0, 16'd1, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[6]  = '{16'd751, 1'b0, 16'd1, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[7]  = '{16'd752, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[8]  = '{16'd799, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[9]  = '{16'd800, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
    vec[10] = '{16'hFFFF, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 10'd0,  10'd0, 1'b0};
    vec[11] = '{16'd0,   1'b1, 16'd2, 1'b1, 1'b1, 1'b1, 10'd0,   10'd2, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      step(vec[i].h, vec[i].e);
      chk($sformatf("vec%0d_V", i),   32'(V_counter),   32'(vec[i].v));
      chk($sformatf("vec%0d_hs", i),  32'(hsync),       32'(vec[i].hs));
      chk($sformatf("vec%0d_vs", i),  32'(vsync),       32'(vec[i].vs));
      chk($sformatf("vec%0d_von", i), 32'(video_on),    32'(vec[i].von));
      chk($sformatf("vec%0d_px", i),  32'(pixel_x),     32'(vec[i].px));
      chk($sformatf("vec%0d_py", i),  32'(pixel_y),     32'(vec[i].py));
      chk($sformatf("vec%0d_fs", i),  32'(frame_start), 32'(vec[i].fs));
    end

    // Full sweep of line 5
    adv_to(4);
    sweep();
    chk("l5_V", 32'(V_counter), 32'd5);
    chk("l5_hs_low", 32'(hs_low), 32'd96);
    chk("l5_hs_first", 32'(first_hs), 32'd656);
    chk("l5_von", 32'(von_hi), 32'd640);

    // Bottom-right visible corner and first blank line
    adv_to(479);
    step(16'd639, 1'b0);
    chk("br_von", 32'(video_on), 32'd1);
    chk("br_px", 32'(pixel_x), 32'd639);
    chk("br_py", 32'(pixel_y), 32'd479);
    step(16'd640, 1'b0);
    chk("br640_von", 32'(video_on), 32'd0);
    chk("br640_px", 32'(pixel_x), 32'd0);
    step(16'd0, 1'b1);
    chk("l480_von", 32'(video_on), 32'd0);
    chk("l480_py", 32'(pixel_y), 32'd0);

    // Vertical sync window
    adv_to(489);
    step(16'd400, 1'b0);
    chk("l489_vs", 32'(vsync), 32'd1);
    vs_low = 0;
    sweep();
    sweep();
    chk("vs_low", 32'(vs_low), 32'd1600);
    chk("l491_V", 32'(V_counter), 32'd491);
    step(16'd0, 1'b1);
    chk("l492_vs", 32'(vsync), 32'd1);

    // Frame wrap and frame_start
    adv_to(524);
    chk("pre_wrap_fs_cnt", 32'(fs_cnt), 32'd0);
    step(16'd0, 1'b1);
    chk("wrap_V", 32'(V_counter), 32'd0);
    chk("wrap_fs", 32'(frame_start), 32'd1);
    chk("wrap_von", 32'(video_on), 32'd1);
    chk("wrap_py", 32'(pixel_y), 32'd0);
    step(16'd1, 1'b0);
    chk("wrap_fs_drop", 32'(frame_start), 32'd0);
    chk("fs_cnt", 32'(fs_cnt), 32'd1);

    // Mid-frame asynchronous reset
    adv_to(300);
    step(16'd400, 1'b0);
    chk("l300_px", 32'(pixel_x), 32'd400);
    chk("l300_py", 32'(pixel_y), 32'd300);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    cur_v = 0;
    step(16'd401, 1'b0);
    chk("post_V", 32'(V_counter), 32'd0);
    chk("post_px", 32'(pixel_x), 32'd401);
    chk("post_py", 32'(pixel_y), 32'd0);
    chk("post_x", 32'($isunknown({V_counter, hsync, vsync, video_on, pixel_x, pixel_y, frame_start})), 32'd0);
    step(16'd0, 1'b1);
    chk("post_adv_V", 32'(V_counter), 32'd1);
    chk("post_adv_py", 32'(pixel_y), 32'd1);

`ifdef VGA_FRAME_CNT_EN
    // Three frames via fast lines
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_v = 0;
    chk("fc_reset", 32'(frame_cnt), 32'd0);
    for (int i = 0; i < 3 * 525; i++) step(16'd0, 1'b1);
    step(16'd800, 1'b0);
    chk("fc_three", 32'(frame_cnt), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Downstream stage of the horizontal pixel counter in the VGA path. Consumes the horizontal count and the end-of-line strobe ena_V, and maintains the vertical line counter. Decodes both counts into registered hsync, vsync, video_on, pixel coordinates and a frame-start strobe for the key/note renderer. Default timing is 640x480@60 (800x525 total, 25 MHz pixel clock).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch (H_TOTAL = sum = 800)
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch (V_TOTAL = sum = 525)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
ena_V  in  1  end-of-line strobe from horizontal counter; high for the one cycle in which H_counter==0
H_counter  in  16  horizontal count, 0..H_TOTAL-1
V_counter  out  16  vertical line count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
video_on  out  1  high inside the visible area
pixel_x  out  10  visible column, 0..H_VISIBLE-1; 0 when blanked
pixel_y  out  10  visible row, 0..V_VISIBLE-1; 0 when blanked
frame_start  out  1  one-cycle pulse at pixel (0,0)

Behaviour:
- Reset (async assert, sync release): V_counter=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0.
- Vertical counter: on each clk edge with ena_V=1, V_counter <= (V_counter==V_TOTAL-1) ? 0 : V_counter+1. Otherwise it holds.
- Line alignment: ena_V coincides with H_counter==0, so the effective line is v_line = ena_V ? next(V_counter) : V_counter, using the same wrap. All decodes use (H_counter, v_line). A new line therefore starts exactly at H_counter==0.
- Decode, registered, latency 1 clk from H_counter:
  - video_on = H_counter<H_VISIBLE && v_line<V_VISIBLE
  - hsync = 0 iff H_VISIBLE+H_FRONT <= H_counter < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default)
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v_line < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default)
  - pixel_x = H_counter[9:0] and pixel_y = v_line[9:0] when video_on; both 0 otherwise
  - frame_start = (H_counter==0 && v_line==0)
- Out-of-range H_counter (>= H_TOTAL): treated as blanking. video_on=0, hsync=1, and no counter change unless ena_V is high.
- ena_V while V_counter >= V_TOTAL cannot occur after reset. If forced, it wraps to 0.
- Reset mid-frame: the upstream counter is not reset, so V_counter restarts at 0 at an arbitrary H position. Alignment recovers at the next ena_V. One shortened first line is permitted.
- Width rule: comparisons are done at 16 bits. Pixel outputs truncate to 10 bits, which is valid because both visible dimensions are below 1024.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: adds output frame_cnt (16 bits), reset to 0. It increments, wrapping modulo 2^16, on every cycle where frame_start is registered high. Used by the game for falling-note animation timing.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the eight timing constants as default values
  - the derived H_TOTAL, V_TOTAL and sync start/end constants
  - the pixel coordinate width constant (10)
- Sub-module vga_line_counter: holds V_counter and produces v_line. Inputs clk, rst_n, ena_V; parameter V_TOTAL.
- The sync/blank decode and output registers stay in the top module.

Test Plan:
- Reset released, upstream free-running 800 clks -> V_counter 0->1 on the edge where ena_V=1. With H_counter=0 and ena_V=1, the next cycle shows pixel_y=1 and pixel_x=0.
- H_counter sweep 0..799 on line 5 -> hsync low for exactly 96 cycles, first low one cycle after H_counter=656. video_on high for 640 cycles.
- Run 525 lines -> vsync low throughout lines 490 and 491 (1600 cycles). V_counter wraps 524->0. frame_start pulses once, one cycle after H=0 of line 0.
- H_counter=639 with v_line=479 -> next cycle video_on=1, pixel_x=639, pixel_y=479. At H_counter=640 -> video_on=0 and pixel_x=0.
- rst_n pulsed low at line 300, H=400 -> outputs return to reset values immediately. After release, V_counter=0 and advances on the next ena_V. No X on any output.
- With VGA_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 3. Force frame_cnt to 16'hFFFF, then one frame -> 0.
